// File: rtl/vc_credit_arbiter.sv
// -----------------------------------------------------------------------------
// vc_credit_arbiter
//
// Shares one NoC injection slot among NUM_REQ local requesters. Each request's
// destination router is looked up in a built-in DEST->VC table, eligibility is
// gated by a per-VC downstream credit counter, and one eligible requester per
// cycle is granted round-robin into a single registered output slot.
//
// Ports
//   clk           in   1                      clock
//   rst           in   1                      synchronous, active-high reset
//   req_valid     in   NUM_REQ                per-requester request
//   req_dest      in   NUM_REQ*N_ADDR_WIDTH   dest of requester i at [i*N_ADDR_WIDTH +: N_ADDR_WIDTH]
//   req_ready     out  NUM_REQ                one-hot accept (transfer on valid & ready)
//   out_valid     out  1                      output slot holds a granted request
//   out_dest      out  N_ADDR_WIDTH           granted destination
//   out_vc        out  VC_ADDR_WIDTH          looked-up VC of the granted request
//   out_req_id    out  $clog2(NUM_REQ)        index of the granted requester
//   err_flag      out  1                      sticky error (only with VC_ARB_ERR_EN)
//   out_ready     in   1                      fabric pops the slot on out_valid & out_ready
//   credit_valid  in   1                      one credit returned this cycle
//   credit_vc     in   VC_ADDR_WIDTH          VC of the returned credit
//
// Configuration
//   VC_ARB_ERR_EN  when defined, adds err_flag: sticky-set the cycle after a
//                  valid request misses the table or a credit is returned to a
//                  counter already at CREDITS. Cleared only by rst.
// -----------------------------------------------------------------------------
module vc_credit_arbiter #(
  parameter int N             = 16,
  parameter int NUM_VC        = 2,
  parameter int N_ADDR_WIDTH  = $clog2(N),
  parameter int VC_ADDR_WIDTH = $clog2(NUM_VC),
  parameter int NUM_DEST      = 4,
  parameter logic [N_ADDR_WIDTH-1:0]  DEST [NUM_DEST] = '{default: N_ADDR_WIDTH'(1)},
  parameter logic [VC_ADDR_WIDTH-1:0] VC   [NUM_DEST] = '{default: VC_ADDR_WIDTH'(1)},
  parameter int NUM_REQ       = 4,
  parameter int CREDITS       = 4,
  parameter int CRED_WIDTH    = $clog2(CREDITS + 1)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ*N_ADDR_WIDTH-1:0]   req_dest,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic                              out_valid,
  output logic [N_ADDR_WIDTH-1:0]           out_dest,
  output logic [VC_ADDR_WIDTH-1:0]          out_vc,
  output logic [$clog2(NUM_REQ)-1:0]        out_req_id,
`ifdef VC_ARB_ERR_EN
  output logic                              err_flag,
`endif
  input  logic                              out_ready,
  input  logic                              credit_valid,
  input  logic [VC_ADDR_WIDTH-1:0]          credit_vc
);

  localparam int ID_WIDTH = $clog2(NUM_REQ);
  localparam logic [CRED_WIDTH-1:0] CRED_MAX = CRED_WIDTH'(CREDITS);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CRED_WIDTH-1:0] credit     [NUM_VC];
  logic [CRED_WIDTH-1:0] credit_nxt [NUM_VC];
  logic [ID_WIDTH-1:0]   rr_ptr;

  // ---------------------------------------------------------------------------
  // Per-requester table lookup
  // ---------------------------------------------------------------------------
  logic [N_ADDR_WIDTH-1:0]  dest_of [NUM_REQ];
  logic [VC_ADDR_WIDTH-1:0] vc_of   [NUM_REQ];
  logic [NUM_REQ-1:0]       hit;
  logic [NUM_REQ-1:0]       eligible;

  // NOTE: every signal driven here gets a default before any conditional
  // assignment, otherwise a path that skips the assignment infers a latch.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      dest_of[i] = req_dest[i*N_ADDR_WIDTH +: N_ADDR_WIDTH];
      hit[i]     = 1'b0;
      vc_of[i]   = '0;
      // Scan high-to-low so the lowest matching entry is the one that sticks.
      for (int k = NUM_DEST - 1; k >= 0; k--) begin
        if (DEST[k] == dest_of[i]) begin
          hit[i]   = 1'b1;
          vc_of[i] = VC[k];
        end
      end
    end
  end

  // A table miss is never eligible, so it only ever stalls its own requester.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = req_valid[i] && hit[i] && (credit[vc_of[i]] != '0);
    end
  end

  // ---------------------------------------------------------------------------
  // Round-robin arbitration
  // ---------------------------------------------------------------------------
  logic                 slot_free;
  logic                 grant_any;
  logic [ID_WIDTH-1:0]  winner;
  logic [ID_WIDTH-1:0]  scan_idx;
  logic [VC_ADDR_WIDTH-1:0] grant_vc;

  // A popped slot can be refilled in the same cycle: full throughput.
  assign slot_free = !out_valid || out_ready;

  always_comb begin
    grant_any = 1'b0;
    winner    = '0;
    scan_idx  = '0;
    // First eligible requester at or above rr_ptr, wrapping at NUM_REQ.
    for (int off = 0; off < NUM_REQ; off++) begin
      scan_idx = ID_WIDTH'((int'(rr_ptr) + off) % NUM_REQ);
      if (!grant_any && eligible[scan_idx]) begin
        grant_any = 1'b1;
        winner    = scan_idx;
      end
    end
    // No accept while in reset or while the slot is held by a stalled output.
    if (rst || !slot_free) begin
      grant_any = 1'b0;
    end
  end

  assign grant_vc  = vc_of[winner];
  assign req_ready = grant_any ? (NUM_REQ'(1) << winner) : '0;

  // ---------------------------------------------------------------------------
  // Credit counters
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int v = 0; v < NUM_VC; v++) begin
      credit_nxt[v] = credit[v];
      if (credit_valid && (credit_vc == VC_ADDR_WIDTH'(v))) begin
        // Return with a same-VC grant cancels out; otherwise saturate at max.
        if (!(grant_any && (grant_vc == VC_ADDR_WIDTH'(v))) && (credit[v] != CRED_MAX)) begin
          credit_nxt[v] = credit[v] + CRED_WIDTH'(1);
        end
      end else if (grant_any && (grant_vc == VC_ADDR_WIDTH'(v))) begin
        // Eligibility required credit != 0, so this cannot underflow.
        credit_nxt[v] = credit[v] - CRED_WIDTH'(1);
      end
    end
  end

  // NOTE: the credit array is reset explicitly, unlike a data memory: the
  // arbiter's correctness depends on every counter restarting at CREDITS.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int v = 0; v < NUM_VC; v++) begin
        credit[v] <= CRED_MAX;
      end
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        credit[v] <= credit_nxt[v];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output slot and round-robin pointer
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_dest   <= '0;
      out_vc     <= '0;
      out_req_id <= '0;
      rr_ptr     <= '0;
    end else if (grant_any) begin
      out_valid  <= 1'b1;
      out_dest   <= dest_of[winner];
      out_vc     <= grant_vc;
      out_req_id <= winner;
      rr_ptr     <= (winner == ID_WIDTH'(NUM_REQ - 1)) ? '0 : winner + ID_WIDTH'(1);
    end else if (out_ready) begin
      // Popped with nothing to refill: slot empties, payload left as is.
      out_valid  <= 1'b0;
    end
  end

`ifdef VC_ARB_ERR_EN
  // ---------------------------------------------------------------------------
  // Sticky error flag
  // ---------------------------------------------------------------------------
  logic miss_seen;
  logic over_return;

  assign miss_seen   = |(req_valid & ~hit);
  assign over_return = credit_valid && (credit[credit_vc] == CRED_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      err_flag <= 1'b0;
    end else if (miss_seen || over_return) begin
      err_flag <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_vc_credit_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vc_credit_arbiter
//
// Self-checking bench for vc_credit_arbiter with DEST={1,2,3,4}, VC={0,1,0,1},
// NUM_REQ=4, CREDITS=4. Directed scenarios followed by randomized traffic, all
// compared cycle by cycle against a behavioural reference model.
// -----------------------------------------------------------------------------
module tb_vc_credit_arbiter;

  localparam int NR  = 4;
  localparam int CR  = 4;
  localparam int NAW = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [NR-1:0]  req_valid;
  logic [NR*NAW-1:0] req_dest;
  logic [NR-1:0]  req_ready;
  logic           out_valid;
  logic [NAW-1:0] out_dest;
  logic           out_vc;
  logic [1:0]     out_req_id;
  logic           out_ready;
  logic           credit_valid;
  logic           credit_vc;
`ifdef VC_ARB_ERR_EN
  logic           err_flag;
`endif

  vc_credit_arbiter #(
    .N        (16),
    .NUM_VC   (2),
    .NUM_DEST (4),
    .DEST     ('{4'd1, 4'd2, 4'd3, 4'd4}),
    .VC       ('{1'b0, 1'b1, 1'b0, 1'b1}),
    .NUM_REQ  (NR),
    .CREDITS  (CR)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_dest     (req_dest),
    .req_ready    (req_ready),
    .out_valid    (out_valid),
    .out_dest     (out_dest),
    .out_vc       (out_vc),
    .out_req_id   (out_req_id),
`ifdef VC_ARB_ERR_EN
    .err_flag     (err_flag),
`endif
    .out_ready    (out_ready),
    .credit_valid (credit_valid),
    .credit_vc    (credit_vc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: destination table, credit pool, RR pointer, one slot.
  // ---------------------------------------------------------------------------
  int tbl_dest [4] = '{1, 2, 3, 4};
  int tbl_vc   [4] = '{0, 1, 0, 1};

  bit m_valid;
  int m_dest, m_vc, m_id;
  int m_cred [2];
  int m_rr;
  bit m_err;
  bit m_show;          // payload is defined (just after reset or while valid)

  int dst [NR];        // per-requester destination for the next cycle
  logic [NR-1:0] last_ready;

  // Returns the VC of the first table entry for d, or -1 on a miss.
  function automatic int lookup(input int d);
    for (int k = 0; k < 4; k++) begin
      if (tbl_dest[k] == d) return tbl_vc[k];
    end
    return -1;
  endfunction

  function automatic int oh_idx(input logic [NR-1:0] v);
    for (int i = 0; i < NR; i++) begin
      if (v == (NR'(1) << i)) return i;
    end
    return -1;
  endfunction

  // One clock cycle: drive, compare mid-cycle, then advance the model.
  task automatic cycle(input bit r, input logic [NR-1:0] rv, input bit ordy,
                       input bit cv, input bit cvc);
    int w;
    int c;
    logic [NR-1:0] exp_ready;
    rst          = r;
    req_valid    = rv;
    for (int i = 0; i < NR; i++) req_dest[i*NAW +: NAW] = NAW'(dst[i]);
    out_ready    = ordy;
    credit_valid = cv;
    credit_vc    = cvc;
    #4;

    w = -1;
    if (!r && (!m_valid || ordy)) begin
      for (int off = 0; off < NR; off++) begin
        int i;
        int v;
        i = (m_rr + off) % NR;
        v = lookup(dst[i]);
        if (w < 0 && rv[i] && v >= 0 && m_cred[v] > 0) w = i;
      end
    end
    exp_ready = (w < 0) ? '0 : NR'(1) << w;

    check("req_ready", req_ready, exp_ready);
    check("out_valid", out_valid, m_valid);
    if (m_valid || m_show) begin
      check("out_dest",   out_dest,   m_dest);
      check("out_vc",     out_vc,     m_vc);
      check("out_req_id", out_req_id, m_id);
    end
`ifdef VC_ARB_ERR_EN
    check("err_flag", err_flag, m_err);
`endif
    last_ready = req_ready;

    @(posedge clk);
    if (r) begin
      m_valid = 0; m_dest = 0; m_vc = 0; m_id = 0;
      m_cred  = '{CR, CR};
      m_rr    = 0; m_err = 0; m_show = 1;
    end else begin
      for (int i = 0; i < NR; i++) if (rv[i] && lookup(dst[i]) < 0) m_err = 1;
      if (cv && m_cred[cvc] == CR) m_err = 1;
      for (int v = 0; v < 2; v++) begin
        c = m_cred[v];
        if (w >= 0 && lookup(dst[w]) == v) c--;
        if (cv && int'(cvc) == v) c++;
        m_cred[v] = (c > CR) ? CR : c;
      end
      if (w >= 0) begin
        m_valid = 1; m_dest = dst[w]; m_vc = lookup(dst[w]); m_id = w;
        m_rr = (w + 1) % NR;
      end else if (ordy) begin
        m_valid = 0;
      end
      m_show = 0;
    end
    #1;
  endtask

  task automatic set_dst(input int d0, input int d1, input int d2, input int d3);
    dst[0] = d0; dst[1] = d1; dst[2] = d2; dst[3] = d3;
  endtask

  task automatic do_reset();
    cycle(1, '0, 1, 0, 0);
    cycle(1, '0, 1, 0, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  int cnt;
  int seq_exp [5] = '{0, 1, 2, 3, 0};
  int dpool   [6] = '{1, 2, 3, 4, 9, 0};

  initial begin
    rst = 1; req_valid = '0; req_dest = '0; out_ready = 0;
    credit_valid = 0; credit_vc = 0; last_ready = '0;
    m_valid = 0; m_dest = 0; m_vc = 0; m_id = 0; m_cred = '{CR, CR};
    m_rr = 0; m_err = 0; m_show = 0;
    set_dst(1, 1, 1, 1);
    @(posedge clk); #1;

    // Reset: requests pending during rst must not be accepted.
    cycle(1, 4'b1111, 1, 0, 0);
    check("ready_in_rst", last_ready, 4'b0000);
    cycle(1, 4'b1111, 1, 0, 0);

    // Single request to dest 2 (VC1).
    set_dst(2, 1, 1, 1);
    cycle(0, 4'b0001, 1, 0, 0);
    check("first_ready", last_ready, 4'b0001);
    cycle(0, 4'b0000, 1, 0, 0);
    check("first_vc", out_vc, 1'b1);
    check("first_id", out_req_id, 2'd0);

    // Round-robin among four requesters, credits replenished every cycle.
    do_reset();
    set_dst(1, 1, 1, 1);
    for (int n = 0; n < 5; n++) begin
      cycle(0, 4'b1111, 1, n != 0, 0);
      check("rr_order", oh_idx(last_ready), seq_exp[n]);
    end

    // Credit exhaustion then one return buys exactly one more grant.
    do_reset();
    set_dst(1, 1, 1, 1);
    cnt = 0;
    for (int n = 0; n < 8; n++) begin
      cycle(0, 4'b0001, 1, 0, 0);
      cnt += int'(last_ready[0]);
    end
    check("exhaust_cnt", cnt, 4);
    cnt = 0;
    cycle(0, 4'b0001, 1, 1, 0);
    cnt += int'(last_ready[0]);
    for (int n = 0; n < 4; n++) begin
      cycle(0, 4'b0001, 1, 0, 0);
      cnt += int'(last_ready[0]);
    end
    check("refill_cnt", cnt, 1);

    // Counter at 1: simultaneous grant and return leaves it at 1.
    do_reset();
    for (int n = 0; n < 3; n++) cycle(0, 4'b0001, 1, 0, 0);
    cycle(0, 4'b0001, 1, 1, 0);
    check("at1_grant", last_ready, 4'b0001);
    cnt = 0;
    for (int n = 0; n < 4; n++) begin
      cycle(0, 4'b0001, 1, 0, 0);
      cnt += int'(last_ready[0]);
    end
    check("at1_cnt", cnt, 1);

    // Return while saturated is dropped.
    do_reset();
    cycle(0, 4'b0000, 1, 1, 0);
    cnt = 0;
    for (int n = 0; n < 6; n++) begin
      cycle(0, 4'b0001, 1, 0, 0);
      cnt += int'(last_ready[0]);
    end
    check("sat_cnt", cnt, 4);

    // Output stall holds the slot; release grants a new winner at once.
    do_reset();
    set_dst(1, 2, 1, 1);
    cycle(0, 4'b0001, 1, 0, 0);
    for (int n = 0; n < 3; n++) begin
      cycle(0, 4'b0011, 0, 0, 0);
      check("stall_ready", last_ready, 4'b0000);
    end
    check("stall_dest", out_dest, 4'd1);
    cycle(0, 4'b0011, 1, 0, 0);
    check("release_ready", last_ready, 4'b0010);

    // Table miss on req1 never wins; req2 keeps getting served.
    do_reset();
    set_dst(1, 9, 3, 1);
    cnt = 0;
    for (int n = 0; n < 6; n++) begin
      cycle(0, 4'b0110, 1, n != 0, 0);
      check("miss_never", last_ready[1], 1'b0);
      cnt += int'(last_ready[2]);
    end
    check("miss_other_cnt", cnt, 6);

    // Reset mid-stream clears the slot and restores credits.
    cycle(1, 4'b0110, 1, 0, 0);
    check("midrst_ready", last_ready, 4'b0000);
    set_dst(1, 1, 1, 1);
    cnt = 0;
    for (int n = 0; n < 6; n++) begin
      cycle(0, 4'b0001, 1, 0, 0);
      cnt += int'(last_ready[0]);
    end
    check("midrst_cred", cnt, 4);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NR; i++) dst[i] = dpool[$urandom_range(5, 0)];
      cycle($urandom_range(63, 0) == 0, NR'($urandom),
            $urandom_range(3, 0) != 0, $urandom_range(1, 0) == 1,
            $urandom_range(1, 0) == 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
